// File: rtl/boreal_sha_arbiter.sv
// Round-robin session arbiter sharing one SHA-256 engine; port 0 is the boot port.
// Optional idle-ownership watchdog: define SHA_ARB_WDT_EN.
module boreal_sha_arbiter #(
  parameter int NREQ       = 4,
  parameter int ID_W       = 2,
  parameter int WDT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_lock,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_start,
  input  logic [NREQ-1:0]   req_update,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   req_ready,
  output logic [31:0]       req_hash,
  output logic              sha_start,
  output logic              sha_update,
  output logic [31:0]       sha_data,
  input  logic [31:0]       sha_hash,
  input  logic              sha_ready,
  output logic              busy,
  output logic [ID_W-1:0]   owner_id,
  output logic              timeout_evt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]      state;
  logic [NREQ-1:0] revoked;
  logic [NREQ-1:0] elig;
  logic            pick_ok;
  logic [ID_W-1:0] pick_idx;
  logic [31:0]     data_arr [NREQ];
  logic            in_busy;
  logic            own_req;
  logic            own_start;
  logic            own_update;
  logic            wdt_fire;

  for (genvar g = 0; g < NREQ; g++) begin : g_data
    assign data_arr[g] = req_data[32*g +: 32];
  end

  assign in_busy    = (state == S_BUSY);
  assign own_req    = req[owner_id];
  assign own_start  = req_start[owner_id];
  assign own_update = req_update[owner_id];

  always_comb begin
    elig = req & ~revoked;
    if (boot_lock)
      elig = elig & NREQ'(1);
  end

  // Search starts just past the last owner so every port gets its turn.
  always_comb begin
    int j;
    logic [ID_W-1:0] cand;
    pick_ok  = 1'b0;
    pick_idx = owner_id;
    j        = 0;
    cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(owner_id) + k;
      if (j >= NREQ)
        j = j - NREQ;
      cand = ID_W'(j);
      if (!pick_ok && elig[cand]) begin
        pick_ok  = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      gnt      <= '0;
      owner_id <= ID_W'(NREQ-1);
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_ok) begin
            gnt      <= NREQ'(1) << pick_idx;
            owner_id <= pick_idx;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!own_req || wdt_fire) begin
            gnt   <= '0;
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (sha_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SHA_ARB_WDT_EN
  localparam int CW = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;

  logic [CW-1:0] wdt_cnt;
  logic          wdt_idle;

  assign wdt_idle = in_busy & ~own_start & ~own_update & sha_ready;
  assign wdt_fire = wdt_idle & own_req & (wdt_cnt == CW'(WDT_CYCLES-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt     <= '0;
      revoked     <= '0;
      timeout_evt <= 1'b0;
    end else begin
      if (!in_busy || own_start || own_update)
        wdt_cnt <= '0;
      else if (sha_ready)
        wdt_cnt <= wdt_cnt + CW'(1);
      revoked     <= (revoked & req)
                   | (wdt_fire ? NREQ'(1) << owner_id : '0);
      timeout_evt <= wdt_fire;
    end
  end
`else
  logic unused_wdt;
  assign unused_wdt  = ^WDT_CYCLES;
  assign wdt_fire    = 1'b0;
  assign revoked     = '0;
  assign timeout_evt = 1'b0;
`endif

  assign sha_start  = in_busy & own_start;
  assign sha_update = in_busy & own_update;
  assign sha_data   = in_busy ? data_arr[owner_id] : 32'h0;
  assign req_ready  = gnt & {NREQ{sha_ready}};
  assign req_hash   = (|gnt) ? sha_hash : 32'h0;
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_boreal_sha_arbiter.sv
// Directed self-checking bench for boreal_sha_arbiter (NREQ=4, WDT_CYCLES=16).
// Watchdog scenario runs when SHA_ARB_WDT_EN is defined.
module tb_boreal_sha_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         boot_lock;
  logic [3:0]   req;
  logic [3:0]   req_start;
  logic [3:0]   req_update;
  logic [127:0] req_data;
  logic [3:0]   gnt;
  logic [3:0]   req_ready;
  logic [31:0]  req_hash;
  logic         sha_start;
  logic         sha_update;
  logic [31:0]  sha_data;
  logic [31:0]  sha_hash;
  logic         sha_ready;
  logic         busy;
  logic [1:0]   owner_id;
  logic         timeout_evt;

  int n_cmp = 0;
  int n_bad = 0;

  boreal_sha_arbiter #(.NREQ(4), .ID_W(2), .WDT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .boot_lock(boot_lock),
    .req(req), .req_start(req_start), .req_update(req_update),
    .req_data(req_data), .gnt(gnt), .req_ready(req_ready),
    .req_hash(req_hash), .sha_start(sha_start),
    .sha_update(sha_update), .sha_data(sha_data),
    .sha_hash(sha_hash), .sha_ready(sha_ready), .busy(busy),
    .owner_id(owner_id), .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_vals(input string tag);
    n_cmp++;
    if (gnt !== 4'b0 || busy !== 1'b0 || owner_id !== 2'd3 ||
        sha_start !== 1'b0 || sha_update !== 1'b0 ||
        sha_data !== 32'h0 || req_hash !== 32'h0 ||
        req_ready !== 4'b0 || timeout_evt !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: gnt=%b busy=%b id=%0d st=%b up=%b d=%h h=%h rdy=%b to=%b, want all zero, id=3",
               tag, gnt, busy, owner_id, sha_start, sha_update,
               sha_data, req_hash, req_ready, timeout_evt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; boot_lock = 1'b0; req = '0;
    req_start = '0; req_update = '0; req_data = '0;
    sha_hash = 32'hC0DE_F00D; sha_ready = 1'b1;
    repeat (2) step();
    check_reset_vals("reset");
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_boot_session();
    logic [31:0] w;
    boot_lock = 1'b1; req = 4'b0001; sha_ready = 1'b1;
    step();
    n_cmp++;
    if (gnt !== 4'b0001 || owner_id !== 2'd0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL boot_grant: gnt=%b id=%0d busy=%b want 0001 0 1", gnt, owner_id, busy);
    end
    req_start = 4'b0001; req_data[31:0] = 32'h6a09e667;
    #1;
    n_cmp++;
    if (sha_start !== 1'b1 || sha_data !== 32'h6a09e667) begin
      n_bad++;
      $display("FAIL boot_start: start=%b data=%h want 1 6a09e667", sha_start, sha_data);
    end
    n_cmp++;
    if (req_ready !== 4'b0001 || req_hash !== 32'hC0DE_F00D) begin
      n_bad++;
      $display("FAIL boot_ready_hash: rdy=%b hash=%h want 0001 c0def00d", req_ready, req_hash);
    end
    step();
    req_start = '0;
    for (int i = 0; i < 1024; i++) begin
      w = 32'(i) * 32'h0100_0193 + 32'h811c_9dc5;
      req_update = 4'b0001; req_data[31:0] = w;
      #1;
      n_cmp++;
      if (sha_update !== 1'b1 || sha_data !== w) begin
        n_bad++;
        $display("FAIL boot_word[%0d]: up=%b data=%h want 1 %h", i, sha_update, sha_data, w);
      end
      step();
    end
    req_update = '0; req = '0; sha_ready = 1'b0;
    step();
    n_cmp++;
    if (gnt !== 4'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL boot_release: gnt=%b busy=%b want 0000 1", gnt, busy);
    end
    req_start = 4'b0001;
    #1;
    n_cmp++;
    if (sha_start !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_start_blocked: start=%b want 0", sha_start);
    end
    req_start = '0;
    step();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL drain_hold: busy=%b want 1", busy);
    end
    sha_ready = 1'b1;
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_exit: busy=%b want 0", busy);
    end
  endtask

  task automatic test_boot_lock_mask();
    boot_lock = 1'b1; req = 4'b1110;
    step(); step();
    n_cmp++;
    if (gnt !== 4'b0) begin
      n_bad++;
      $display("FAIL lock_mask: gnt=%b want 0000", gnt);
    end
    boot_lock = 1'b0;
    step();
    n_cmp++;
    if (gnt !== 4'b0010 || owner_id !== 2'd1) begin
      n_bad++;
      $display("FAIL lock_release_grant: gnt=%b id=%0d want 0010 1", gnt, owner_id);
    end
    req = '0;
    step(); step();
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0]  eg;
    logic [31:0] ew;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req = 4'b1111; sha_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      step();
      eg = 4'b0001 << order[r];
      n_cmp++;
      if (gnt !== eg || req_ready !== eg) begin
        n_bad++;
        $display("FAIL rr_grant[%0d]: gnt=%b rdy=%b want %b", r, gnt, req_ready, eg);
      end
      for (int w = 0; w < 3; w++) begin
        req_update = 4'b1111;
        for (int p = 0; p < 4; p++)
          req_data[32*p +: 32] = 32'hA000_0000 | 32'(p << 8) | 32'(w);
        ew = 32'hA000_0000 | 32'(order[r] << 8) | 32'(w);
        #1;
        n_cmp++;
        if (sha_update !== 1'b1 || sha_data !== ew || req_ready !== eg) begin
          n_bad++;
          $display("FAIL rr_word[%0d.%0d]: up=%b data=%h rdy=%b want 1 %h %b",
                   r, w, sha_update, sha_data, req_ready, ew, eg);
        end
        step();
      end
      req_update = '0;
      req[order[r]] = 1'b0;
      step();
      n_cmp++;
      if (gnt !== 4'b0 || req_ready !== 4'b0) begin
        n_bad++;
        $display("FAIL rr_release[%0d]: gnt=%b rdy=%b want 0000", r, gnt, req_ready);
      end
      req[order[r]] = 1'b1;
      step();
    end
    req = '0;
    step(); step();
  endtask

  task automatic test_isolation();
    req = 4'b0100;
    step();
    n_cmp++;
    if (gnt !== 4'b0100) begin
      n_bad++;
      $display("FAIL iso_grant: gnt=%b want 0100", gnt);
    end
    req = 4'b0110;
    req_update = 4'b0010;
    req_data[63:32] = 32'hDEAD_BEEF;
    req_data[95:64] = 32'h1234_5678;
    #1;
    n_cmp++;
    if (sha_update !== 1'b0 || sha_data !== 32'h1234_5678 || req_ready[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL iso_foreign: up=%b data=%h rdy1=%b want 0 12345678 0",
               sha_update, sha_data, req_ready[1]);
    end
    req_update = 4'b0110;
    #1;
    n_cmp++;
    if (sha_update !== 1'b1 || sha_data !== 32'h1234_5678) begin
      n_bad++;
      $display("FAIL iso_owner: up=%b data=%h want 1 12345678", sha_update, sha_data);
    end
    step();
  endtask

  task automatic test_reset_mid();
    sha_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid");
    step();
    rst_n = 1'b1;
    req = '0; req_update = '0;
    step();
    n_cmp++;
    if (busy !== 1'b0 || gnt !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_mid_idle: busy=%b gnt=%b want 0 0000", busy, gnt);
    end
    req = 4'b0001; sha_ready = 1'b1;
    step();
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL reset_mid_regrant: gnt=%b want 0001", gnt);
    end
    req = '0;
    step(); step();
  endtask

`ifdef SHA_ARB_WDT_EN
  task automatic test_watchdog();
    req = 4'b0001; sha_ready = 1'b1;
    step();
    for (int k = 0; k < 15; k++) begin
      step();
      n_cmp++;
      if (gnt !== 4'b0001 || timeout_evt !== 1'b0) begin
        n_bad++;
        $display("FAIL wdt_early[%0d]: gnt=%b to=%b want 0001 0", k, gnt, timeout_evt);
      end
    end
    step();
    n_cmp++;
    if (gnt !== 4'b0 || timeout_evt !== 1'b1) begin
      n_bad++;
      $display("FAIL wdt_fire: gnt=%b to=%b want 0000 1", gnt, timeout_evt);
    end
    step();
    n_cmp++;
    if (timeout_evt !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL wdt_pulse_end: to=%b busy=%b want 0 0", timeout_evt, busy);
    end
    step(); step();
    n_cmp++;
    if (gnt !== 4'b0) begin
      n_bad++;
      $display("FAIL wdt_revoked: gnt=%b want 0000", gnt);
    end
    req = '0;
    step();
    req = 4'b0001;
    step();
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL wdt_rearm: gnt=%b want 0001", gnt);
    end
    req = '0;
    step(); step();
  endtask
`else
  task automatic test_watchdog();
    req = 4'b0001; sha_ready = 1'b1;
    step();
    repeat (20) step();
    n_cmp++;
    if (gnt !== 4'b0001 || timeout_evt !== 1'b0) begin
      n_bad++;
      $display("FAIL no_wdt_hold: gnt=%b to=%b want 0001 0", gnt, timeout_evt);
    end
    req = '0;
    step(); step();
  endtask
`endif

  initial begin
    test_reset();
    test_boot_session();
    test_boot_lock_mask();
    test_round_robin();
    test_isolation();
    test_reset_mid();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/boreal_sha_arbiter.md
# boreal_sha_arbiter

Shares the single SHA-256 engine between up to NREQ requesters: boot ROM measured-boot sequencer on port 0, CPU MMIO and DMA hashing on the other ports. Each requester owns the engine for a whole hash session, and grants rotate round-robin. A boot lock reserves the engine for port 0 until boot completes. Ownership always ends in a drain phase, so a new owner never inherits an in-flight compression.

## Interface
Parameters:
- NREQ, 4: number of requester ports (2..8); port 0 is the boot port.
- ID_W, 2: width of owner_id; must satisfy 2**ID_W >= NREQ.
- WDT_CYCLES, 4096: idle-ownership timeout in cycles (used only with the watchdog compiled in).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- boot_lock  in  1  while 1, only req[0] is eligible for grant
- req  in  NREQ  per-port session request (level); dropping it releases ownership
- req_start  in  NREQ  per-port SHA init pulse
- req_update  in  NREQ  per-port SHA word-valid
- req_data  in  32*NREQ  per-port data word; port i occupies bits [32i+31:32i]
- gnt  out  NREQ  one-hot ownership, registered
- req_ready  out  NREQ  sha_ready gated by gnt[i]
- req_hash  out  32  sha_hash while any port owns the engine, else 0
- sha_start  out  1  to engine
- sha_update  out  1  to engine
- sha_data  out  32  to engine
- sha_hash  in  32  from engine
- sha_ready  in  1  from engine
- busy  out  1  state != IDLE
- owner_id  out  ID_W  index of current or last owner
- timeout_evt  out  1  one-cycle pulse on watchdog revoke

## Operation
- State machine with three states: IDLE, BUSY, DRAIN.
- Eligible set: req & ~revoked; masked to bit 0 when boot_lock=1.
- IDLE: if eligible != 0, pick the first set bit searching from owner_id+1 (mod NREQ, wrapping), set gnt to that bit and owner_id to its index, go to BUSY.
- BUSY: sha_start, sha_update and sha_data are the owner's req_start, req_update and req_data, muxed combinationally with zero added latency. If req[owner] = 0, clear gnt and go to DRAIN.
- DRAIN: sha_start = sha_update = 0 and sha_data = 0. When sha_ready = 1, go to IDLE.
- Outside BUSY, engine outputs are forced 0 and the owner's inputs are ignored.
- Non-owners always see req_ready = 0. Any req_start or req_update they drive is dropped silently.
- boot_lock rising while another port owns the engine: no preemption. After that port drains, only port 0 is eligible.
- Reset mid-session: everything returns to reset values. The engine is not cleared; the next owner issues its own start.

## Timing
- Reset values: gnt = 0, req_ready = 0, req_hash = 0, sha_start = 0, sha_update = 0, sha_data = 0, busy = 0, owner_id = NREQ-1 (so port 0 wins first), timeout_evt = 0, revoked = 0, state = IDLE.
- Grant latency: req sampled high in IDLE gives gnt high on the next edge. The first owner word can be forwarded in that same cycle.
- Release: req falls at edge N, gnt falls at edge N+1 (state DRAIN). IDLE is entered on the first edge after that where sha_ready = 1. Minimum re-grant gap is 2 cycles after the release.
- Simultaneous owner release and new request: the new request is evaluated only in IDLE; round-robin order still holds.
- A single port holding req continuously keeps ownership indefinitely (watchdog aside).

## Configuration
- SHA_ARB_WDT_EN defined:
  - In BUSY, a counter counts cycles with req_start = 0, req_update = 0 and sha_ready = 1. Any start or update from the owner clears it.
  - When the counter reaches WDT_CYCLES-1: clear gnt, set revoked[owner], pulse timeout_evt, go to DRAIN.
  - revoked[i] clears when req[i] = 0.
- SHA_ARB_WDT_EN undefined: no counter, no revoked register; timeout_evt is tied to 0.

## Test plan
- Reset, then req = 4'b0001 with boot_lock = 1: gnt = 0001 one cycle later. Feed start plus 1024 words; engine sees each word unchanged in the same cycle. Drop req; gnt = 0 next cycle; busy stays 1 until sha_ready = 1.
- boot_lock = 1 and req = 4'b1110: gnt stays 0. Drop boot_lock: gnt = 0010.
- req = 4'b1111 held, each owner releasing after 3 words: grant order 0, 1, 2, 3, 0. Non-owners always see req_ready = 0.
- Port 2 owns, port 1 drives req_update = 1 with data 0xDEADBEEF: sha_update follows port 2 only; 0xDEADBEEF never reaches sha_data.
- Assert rst_n = 0 mid-session with sha_ready held 0: all outputs reach reset values immediately; state is IDLE after release.
- SHA_ARB_WDT_EN defined with WDT_CYCLES = 16: owner idles 16 cycles, timeout_evt pulses once, gnt = 0. No re-grant to that port until its req drops and rises again.
